// File: rtl/pmem_axi4_master_if.sv
// AXI4 master-side bus bundle for pmem_axi4_master.
// The design's axi_*_o / axi_*_i ports live here, minus the prefix and suffix:
// axi_awvalid_o is awvalid, axi_rdata_i is rdata, and so on.
`timescale 1ns/1ps
interface pmem_axi4_master_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arburst, arsize,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst, arsize,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/pmem_axi4_master.sv
// pmem request port to AXI4 master bridge. One INCR burst outstanding at a
// time; read beats and write completions are returned on ram_ack_o.
// Optional feature macro: PMEM_AXI_ERROR_RESP_EN -- when defined, ram_error_o
// reports a non-OKAY bresp/rresp; otherwise ram_error_o is tied low.
`timescale 1ns/1ps
module pmem_axi4_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [3:0]                ram_wr_i,
  input  logic                      ram_rd_i,
  input  logic [7:0]                ram_len_i,
  input  logic [31:0]               ram_addr_i,
  input  logic [31:0]               ram_write_data_i,
  output logic                      ram_accept_o,
  output logic                      ram_ack_o,
  output logic                      ram_error_o,
  output logic [31:0]               ram_read_data_o,
  pmem_axi4_master_if.master        axi
);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [7:0]  len_reg;
  logic [8:0]  beat_cnt_reg;     // beats accepted so far; 9 bits so len 255 does not wrap
  logic [31:0] wbuf_data_reg;
  logic [3:0]  wbuf_strb_reg;
  logic        wbuf_valid_reg;
  logic        wbuf_last_reg;
  logic        wlast_done_reg;
  logic        awvalid_reg;
  logic        aw_done_reg;
  logic        arvalid_reg;
  logic        rready_reg;
  logic        bready_reg;
  logic        ack_reg;
  logic        error_reg;
  logic [31:0] rdata_reg;

  logic wr_req;
  logic w_hs;
  logic aw_hs;
  logic ar_hs;
  logic r_hs;
  logic wlast_now;
  logic accept_write;
  logic b_err;
  logic r_err;

  assign wr_req    = |ram_wr_i;
  assign w_hs      = wbuf_valid_reg & axi.wready;
  assign aw_hs     = awvalid_reg & axi.awready;
  assign ar_hs     = arvalid_reg & axi.arready;
  assign r_hs      = rready_reg & axi.rvalid;
  assign wlast_now = w_hs & wbuf_last_reg;

  // A new write beat can be taken while the burst is not complete and the
  // holding register is empty or draining this cycle.
  assign accept_write = (state_reg == WRITE) && wr_req &&
                        (beat_cnt_reg <= {1'b0, len_reg}) &&
                        (!wbuf_valid_reg || w_hs);

  assign ram_accept_o = (state_reg == IDLE) || accept_write;

`ifdef PMEM_AXI_ERROR_RESP_EN
  assign b_err = |axi.bresp;
  assign r_err = |axi.rresp;
`else
  assign b_err = 1'b0;
  assign r_err = 1'b0;
`endif

  assign ram_ack_o       = ack_reg;
  assign ram_error_o     = error_reg;
  assign ram_read_data_o = rdata_reg;

  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = len_reg;
  assign axi.awburst = 2'b01;
  assign axi.awsize  = 3'b010;
  assign axi.wvalid  = wbuf_valid_reg;
  assign axi.wdata   = wbuf_data_reg;
  assign axi.wstrb   = wbuf_strb_reg;
  assign axi.wlast   = wbuf_valid_reg & wbuf_last_reg;
  assign axi.bready  = bready_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = addr_reg;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = len_reg;
  assign axi.arburst = 2'b01;
  assign axi.arsize  = 3'b010;
  assign axi.rready  = rready_reg;

  // Burst sequencer: request capture, AW/W/B and AR/R handshakes, ack pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      len_reg        <= '0;
      beat_cnt_reg   <= '0;
      wbuf_data_reg  <= '0;
      wbuf_strb_reg  <= '0;
      wbuf_valid_reg <= 1'b0;
      wbuf_last_reg  <= 1'b0;
      wlast_done_reg <= 1'b0;
      awvalid_reg    <= 1'b0;
      aw_done_reg    <= 1'b0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      ack_reg        <= 1'b0;
      error_reg      <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      ack_reg   <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wr_req) begin
            addr_reg       <= ram_addr_i;
            len_reg        <= ram_len_i;
            wbuf_data_reg  <= ram_write_data_i;
            wbuf_strb_reg  <= ram_wr_i;
            wbuf_valid_reg <= 1'b1;
            wbuf_last_reg  <= (ram_len_i == 8'd0);
            beat_cnt_reg   <= 9'd1;
            awvalid_reg    <= 1'b1;
            aw_done_reg    <= 1'b0;
            wlast_done_reg <= 1'b0;
            state_reg      <= WRITE;
          end else if (ram_rd_i) begin
            addr_reg    <= ram_addr_i;
            len_reg     <= ram_len_i;
            arvalid_reg <= 1'b1;
            state_reg   <= READ;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (accept_write) begin
            wbuf_data_reg  <= ram_write_data_i;
            wbuf_strb_reg  <= ram_wr_i;
            wbuf_valid_reg <= 1'b1;
            wbuf_last_reg  <= (beat_cnt_reg == {1'b0, len_reg});
            beat_cnt_reg   <= beat_cnt_reg + 9'd1;
          end else if (w_hs) begin
            wbuf_valid_reg <= 1'b0;
          end
          if (wlast_now) begin
            wlast_done_reg <= 1'b1;
          end
          // AW and the final W beat may complete in either order.
          if ((aw_done_reg || aw_hs) && (wlast_done_reg || wlast_now)) begin
            bready_reg <= 1'b1;
            state_reg  <= WRESP;
          end
        end
        WRESP: begin
          if (axi.bvalid) begin
            bready_reg <= 1'b0;
            ack_reg    <= 1'b1;
            error_reg  <= b_err;
            state_reg  <= IDLE;
          end
        end
        READ: begin
          if (ar_hs) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
          end
          if (r_hs) begin
            rdata_reg <= axi.rdata;
            ack_reg   <= 1'b1;
            error_reg <= r_err;
            if (axi.rlast) begin
              rready_reg <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_axi4_master.sv
// Directed bench for pmem_axi4_master: a cycle-stepped requester and AXI slave
// model, with one task per scenario doing its own comparisons.
`timescale 1ns/1ps
module tb_pmem_axi4_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  ram_wr_i = '0;
  logic        ram_rd_i = 1'b0;
  logic [7:0]  ram_len_i = '0;
  logic [31:0] ram_addr_i = '0;
  logic [31:0] ram_write_data_i = '0;
  logic        ram_accept_o;
  logic        ram_ack_o;
  logic        ram_error_o;
  logic [31:0] ram_read_data_o;

  pmem_axi4_master_if bus ();

  pmem_axi4_master #(.AXI_ID(4'd0)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ram_wr_i         (ram_wr_i),
    .ram_rd_i         (ram_rd_i),
    .ram_len_i        (ram_len_i),
    .ram_addr_i       (ram_addr_i),
    .ram_write_data_i (ram_write_data_i),
    .ram_accept_o     (ram_accept_o),
    .ram_ack_o        (ram_ack_o),
    .ram_error_o      (ram_error_o),
    .ram_read_data_o  (ram_read_data_o),
    .axi              (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Observations collected by run_txn.
  int          ack_n, w_n, w_last_n, w_last_idx, w_bad, w_done_cyc;
  int          aw_n, aw_cyc, b_cyc, bready_first, ar_n, ar_cyc, valid_drop, timeout;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  aw_len_seen, ar_len_seen;
  logic [31:0] ack_data [0:63];
  logic        ack_err  [0:63];
  int          ack_cyc  [0:63];

`ifdef PMEM_AXI_ERROR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  task automatic idle_inputs();
    ram_wr_i = '0; ram_rd_i = 1'b0; ram_len_i = '0; ram_addr_i = '0; ram_write_data_i = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rid = '0; bus.rlast = 1'b0;
  endtask

  // Requester + AXI slave model, stepped once per cycle at the falling edge.
  task automatic run_txn(input bit wr_en, input logic [31:0] waddr, input logic [7:0] wlen,
                         input logic [31:0] wpat, input int aw_delay, input logic [1:0] bresp,
                         input bit rd_en, input logic [31:0] raddr, input logic [7:0] rlen,
                         input logic [31:0] rbase, input int err_beat, input int abort_rbeat);
    int sent = 0, rbeat = 0, wacc_cyc = -1, done_cyc = -1, expect_n;
    bit rd_acc = 0, b_done = 0, pw = 0, pwr = 0, paw = 0, pawr = 0, par = 0, parr = 0;
    ack_n = 0; w_n = 0; w_last_n = 0; w_last_idx = -1; w_bad = 0; w_done_cyc = -1;
    aw_n = 0; aw_cyc = -1; b_cyc = -1; bready_first = -1; ar_n = 0; ar_cyc = -1;
    valid_drop = 0; timeout = 1; aw_addr_seen = '0; ar_addr_seen = '0; aw_len_seen = '0; ar_len_seen = '0;
    expect_n = (wr_en ? 1 : 0) + (rd_en ? int'(rlen) + 1 : 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk_i);
      if ((pw && !pwr && !bus.wvalid) || (paw && !pawr && !bus.awvalid) || (par && !parr && !bus.arvalid))
        valid_drop++;
      if (ram_ack_o && ack_n < 64) begin
        ack_data[ack_n] = ram_read_data_o; ack_err[ack_n] = ram_error_o; ack_cyc[ack_n] = cyc; ack_n++;
      end
      if (ack_n >= expect_n && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin timeout = 0; break; end
      // requester
      ram_wr_i         = (wr_en && sent <= int'(wlen)) ? (sent[0] ? 4'h3 : 4'hF) : 4'h0;
      ram_write_data_i = 32'hA500_0000 | sent;
      ram_rd_i         = rd_en && !rd_acc;
      if (ram_wr_i != 0) begin
        ram_addr_i = (sent == 0) ? waddr : 32'hFFFF_FFF0;
        ram_len_i  = (sent == 0) ? wlen : 8'hEE;
      end else begin
        ram_addr_i = raddr; ram_len_i = rlen;
      end
      // slave
      bus.wready  = (wacc_cyc >= 0 && cyc - wacc_cyc - 1 < 32) ? wpat[cyc - wacc_cyc - 1] : 1'b1;
      bus.awready = (aw_delay < 0) ? 1'b1 : (w_done_cyc >= 0 && cyc > w_done_cyc + aw_delay);
      bus.bvalid  = (aw_n > 0) && (w_done_cyc >= 0) && !b_done;
      bus.bresp   = bresp;
      bus.arready = 1'b1;
      bus.rvalid  = (ar_n > 0) && (rbeat <= int'(rlen));
      bus.rdata   = rbase + rbeat;
      bus.rlast   = (rbeat == int'(rlen));
      bus.rresp   = (rbeat == err_beat) ? 2'b10 : 2'b00;
      if (abort_rbeat >= 0 && rbeat == abort_rbeat && bus.rvalid) begin timeout = 0; return; end
      #1;
      if (ram_accept_o) begin
        if (ram_wr_i != 0) begin
          if (sent == 0) wacc_cyc = cyc;
          sent++;
        end else if (ram_rd_i) rd_acc = 1;
      end
      if (bus.wvalid && bus.wready) begin
        if (bus.wdata !== (32'hA500_0000 | w_n) || bus.wstrb !== (w_n[0] ? 4'h3 : 4'hF)) w_bad++;
        if (bus.wlast) begin w_last_n++; w_last_idx = w_n; w_done_cyc = cyc; end
        w_n++;
      end
      if (bus.awvalid && bus.awready) begin aw_n++; aw_cyc = cyc; aw_addr_seen = bus.awaddr; aw_len_seen = bus.awlen; end
      if (bus.bready && bready_first < 0) bready_first = cyc;
      if (bus.bvalid && bus.bready) begin b_done = 1; b_cyc = cyc; end
      if (bus.arvalid && bus.arready) begin ar_n++; ar_cyc = cyc; ar_addr_seen = bus.araddr; ar_len_seen = bus.arlen; end
      if (bus.rvalid && bus.rready) rbeat++;
      pw = bus.wvalid; pwr = bus.wready; paw = bus.awvalid; pawr = bus.awready; par = bus.arvalid; parr = bus.arready;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid: got %b want 0", bus.awvalid); end
    n_cmp++; if (bus.wvalid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid: got %b want 0", bus.wvalid); end
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", bus.arvalid); end
    n_cmp++; if ({bus.bready, bus.rready} !== 2'b00) begin n_err++; $display("FAIL rst_readys: got %b want 00", {bus.bready, bus.rready}); end
    n_cmp++; if ({ram_ack_o, ram_error_o} !== 2'b00) begin n_err++; $display("FAIL rst_ack_err: got %b want 00", {ram_ack_o, ram_error_o}); end
    n_cmp++; if (ram_accept_o !== 1'b1) begin n_err++; $display("FAIL rst_accept: got %b want 1", ram_accept_o); end
    n_cmp++; if (ram_read_data_o !== 32'h0 || bus.awaddr !== 32'h0 || bus.arlen !== 8'h0 || bus.wdata !== 32'h0)
      begin n_err++; $display("FAIL rst_data: rdata %h awaddr %h arlen %h wdata %h want all 0", ram_read_data_o, bus.awaddr, bus.arlen, bus.wdata); end
    n_cmp++; if ({bus.awburst, bus.awsize, bus.arburst, bus.arsize} !== {2'b01, 3'b010, 2'b01, 3'b010})
      begin n_err++; $display("FAIL const_burst_size: got %b want 0101001010", {bus.awburst, bus.awsize, bus.arburst, bus.arsize}); end
    n_cmp++; if ({bus.awid, bus.arid} !== 8'h00) begin n_err++; $display("FAIL ids: got %h want 00", {bus.awid, bus.arid}); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_single_read();
    run_txn(0, 0, 0, 0, -1, 0, 1, 32'h1000, 8'd0, 32'hDEADBEEF, -1, -1);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL rd1_timeout: got %0d want 0", timeout); end
    n_cmp++; if (ack_n !== 1) begin n_err++; $display("FAIL rd1_acks: got %0d want 1", ack_n); end
    n_cmp++; if (ack_data[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd1_data: got %h want deadbeef", ack_data[0]); end
    n_cmp++; if (ar_addr_seen !== 32'h1000 || ar_len_seen !== 8'd0 || ar_n !== 1)
      begin n_err++; $display("FAIL rd1_ar: addr %h len %0d n %0d want 1000/0/1", ar_addr_seen, ar_len_seen, ar_n); end
    n_cmp++; if (ack_err[0] !== 1'b0) begin n_err++; $display("FAIL rd1_err: got %b want 0", ack_err[0]); end
    #1;
    n_cmp++; if (ram_accept_o !== 1'b1 || bus.rready !== 1'b0) begin n_err++; $display("FAIL rd1_idle: accept %b rready %b want 1/0", ram_accept_o, bus.rready); end
    $display("single_read: acks %0d data %h", ack_n, ack_data[0]);
  endtask

  task automatic test_write4();
    run_txn(1, 32'h2000, 8'd3, 32'b11101, -1, 2'b00, 0, 0, 0, 0, -1, -1);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL wr4_timeout: got %0d want 0", timeout); end
    n_cmp++; if (w_n !== 4) begin n_err++; $display("FAIL wr4_beats: got %0d want 4", w_n); end
    n_cmp++; if (w_last_n !== 1 || w_last_idx !== 3) begin n_err++; $display("FAIL wr4_wlast: count %0d idx %0d want 1/3", w_last_n, w_last_idx); end
    n_cmp++; if (w_bad !== 0) begin n_err++; $display("FAIL wr4_wdata: bad beats %0d want 0", w_bad); end
    n_cmp++; if (aw_n !== 1 || aw_addr_seen !== 32'h2000 || aw_len_seen !== 8'd3)
      begin n_err++; $display("FAIL wr4_aw: n %0d addr %h len %0d want 1/2000/3", aw_n, aw_addr_seen, aw_len_seen); end
    n_cmp++; if (ack_n !== 1 || ack_cyc[0] !== b_cyc + 1) begin n_err++; $display("FAIL wr4_ack: n %0d cyc %0d want 1 at %0d", ack_n, ack_cyc[0], b_cyc + 1); end
    n_cmp++; if (valid_drop !== 0) begin n_err++; $display("FAIL wr4_valid_hold: drops %0d want 0", valid_drop); end
    $display("write4: beats %0d wlast_idx %0d acks %0d", w_n, w_last_idx, ack_n);
  endtask

  task automatic test_aw_late();
    run_txn(1, 32'h2400, 8'd1, 32'hFFFF_FFFF, 5, 2'b00, 0, 0, 0, 0, -1, -1);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL awlate_timeout: got %0d want 0", timeout); end
    n_cmp++; if (aw_cyc !== w_done_cyc + 6) begin n_err++; $display("FAIL awlate_aw_cyc: got %0d want %0d", aw_cyc, w_done_cyc + 6); end
    n_cmp++; if (bready_first !== aw_cyc + 1) begin n_err++; $display("FAIL awlate_wresp: bready at %0d want %0d", bready_first, aw_cyc + 1); end
    n_cmp++; if (ack_n !== 1 || aw_n !== 1 || w_n !== 2) begin n_err++; $display("FAIL awlate_counts: acks %0d aw %0d w %0d want 1/1/2", ack_n, aw_n, w_n); end
    n_cmp++; if (valid_drop !== 0) begin n_err++; $display("FAIL awlate_valid_hold: drops %0d want 0", valid_drop); end
    $display("aw_late: aw at %0d wlast at %0d bready at %0d", aw_cyc, w_done_cyc, bready_first);
  endtask

  task automatic test_wr_rd_collision();
    run_txn(1, 32'h3000, 8'd0, 32'hFFFF_FFFF, -1, 2'b11, 1, 32'h4000, 8'd0, 32'hCAFEF00D, -1, -1);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL coll_timeout: got %0d want 0", timeout); end
    n_cmp++; if (ack_n !== 2) begin n_err++; $display("FAIL coll_acks: got %0d want 2", ack_n); end
    n_cmp++; if (aw_addr_seen !== 32'h3000 || ar_addr_seen !== 32'h4000)
      begin n_err++; $display("FAIL coll_addrs: aw %h ar %h want 3000/4000", aw_addr_seen, ar_addr_seen); end
    n_cmp++; if (!(aw_cyc < ar_cyc) || ack_cyc[0] !== b_cyc + 1 || !(ack_cyc[0] < ar_cyc))
      begin n_err++; $display("FAIL coll_order: aw %0d ar %0d ack0 %0d b %0d want write first", aw_cyc, ar_cyc, ack_cyc[0], b_cyc); end
    n_cmp++; if (ack_data[1] !== 32'hCAFEF00D) begin n_err++; $display("FAIL coll_rdata: got %h want cafef00d", ack_data[1]); end
    n_cmp++; if (ack_err[0] !== ERR_EN || ack_err[1] !== 1'b0)
      begin n_err++; $display("FAIL coll_err: got %b%b want %b0", ack_err[0], ack_err[1], ERR_EN); end
    $display("collision: acks %0d write ack cyc %0d read ar cyc %0d", ack_n, ack_cyc[0], ar_cyc);
  endtask

  task automatic test_read_error();
    run_txn(0, 0, 0, 0, -1, 0, 1, 32'h5000, 8'd2, 32'h0000_0100, 1, -1);
    n_cmp++; if (timeout !== 0 || ack_n !== 3) begin n_err++; $display("FAIL rderr_acks: timeout %0d acks %0d want 0/3", timeout, ack_n); end
    n_cmp++; if ({ack_err[0], ack_err[1], ack_err[2]} !== {1'b0, ERR_EN, 1'b0})
      begin n_err++; $display("FAIL rderr_flags: got %b%b%b want 0%b0", ack_err[0], ack_err[1], ack_err[2], ERR_EN); end
    n_cmp++; if (ack_data[0] !== 32'h100 || ack_data[1] !== 32'h101 || ack_data[2] !== 32'h102)
      begin n_err++; $display("FAIL rderr_data: got %h %h %h want 100 101 102", ack_data[0], ack_data[1], ack_data[2]); end
    n_cmp++; if (ar_len_seen !== 8'd2) begin n_err++; $display("FAIL rderr_arlen: got %0d want 2", ar_len_seen); end
    $display("read_error: acks %0d flags %b%b%b", ack_n, ack_err[0], ack_err[1], ack_err[2]);
  endtask

  task automatic test_reset_mid_burst();
    run_txn(0, 0, 0, 0, -1, 0, 1, 32'h6000, 8'd7, 32'h7700_0000, -1, 1);
    n_cmp++; if (ack_n !== 1 || ram_read_data_o !== 32'h7700_0000)
      begin n_err++; $display("FAIL rstmid_pre: acks %0d rdata %h want 1/77000000", ack_n, ram_read_data_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0)
      begin n_err++; $display("FAIL rstmid_valids: got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
    n_cmp++; if ({ram_ack_o, ram_error_o, ram_accept_o} !== 3'b001)
      begin n_err++; $display("FAIL rstmid_ram: ack/err/accept %b want 001", {ram_ack_o, ram_error_o, ram_accept_o}); end
    n_cmp++; if (ram_read_data_o !== 32'h0 || bus.araddr !== 32'h0 || bus.arlen !== 8'h0)
      begin n_err++; $display("FAIL rstmid_regs: rdata %h araddr %h arlen %h want 0", ram_read_data_o, bus.araddr, bus.arlen); end
    idle_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_txn(0, 0, 0, 0, -1, 0, 1, 32'h6100, 8'd0, 32'h1234_5678, -1, -1);
    n_cmp++; if (timeout !== 0 || ack_n !== 1 || ack_data[0] !== 32'h1234_5678)
      begin n_err++; $display("FAIL rstmid_post: timeout %0d acks %0d data %h want 0/1/12345678", timeout, ack_n, ack_data[0]); end
    n_cmp++; if (ar_addr_seen !== 32'h6100) begin n_err++; $display("FAIL rstmid_post_addr: got %h want 6100", ar_addr_seen); end
    $display("reset_mid_burst: post-reset acks %0d data %h", ack_n, ack_data[0]);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write4();
    test_aw_late();
    test_wr_rd_collision();
    test_read_error();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmem_axi4_master.md
# pmem_axi4_master

Bridge from the simple pmem request port (ram_* strobes, accept/ack) to an AXI4 master. It is the initiator-side counterpart of our AXI4-to-pmem slave bridge. It sits between a cache or DMA engine that speaks the pmem port and the AXI4 interconnect. It issues one INCR burst at a time (one outstanding transaction) and returns read data or write completion on ram_ack_o.

## Interface
Parameters:
- AXI_ID, default 4'd0: constant value driven on axi_awid_o and axi_arid_o.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- ram_wr_i  in  4  write byte strobes; nonzero means a write beat is presented.
- ram_rd_i  in  1  read request.
- ram_len_i  in  8  burst beats minus 1; sampled on the first beat only.
- ram_addr_i  in  32  byte address; sampled on the first beat only.
- ram_write_data_i  in  32  write data.
- ram_accept_o  out  1  the current beat or request is taken this cycle.
- ram_ack_o  out  1  one pulse per read beat, or one pulse per completed write burst.
- ram_error_o  out  1  error flag, qualified by ram_ack_o.
- ram_read_data_o  out  32  read data, qualified by ram_ack_o.
- axi_awvalid_o / axi_awready_i, axi_awaddr_o[32], axi_awid_o[4], axi_awlen_o[8], axi_awburst_o[2], axi_awsize_o[3]: AW channel.
- axi_wvalid_o / axi_wready_i, axi_wdata_o[32], axi_wstrb_o[4], axi_wlast_o: W channel.
- axi_bvalid_i / axi_bready_o, axi_bresp_i[2], axi_bid_i[4]: B channel.
- axi_arvalid_o / axi_arready_i, axi_araddr_o[32], axi_arid_o[4], axi_arlen_o[8], axi_arburst_o[2], axi_arsize_o[3]: AR channel.
- axi_rvalid_i / axi_rready_o, axi_rdata_i[32], axi_rresp_i[2], axi_rid_i[4], axi_rlast_i: R channel.

## Operation
- Constant outputs: axi_awburst_o and axi_arburst_o = 2'b01 (INCR); axi_awsize_o and axi_arsize_o = 3'b010.
- FSM states: IDLE, WRITE, WRESP, READ. Reset state is IDLE.
- IDLE:
  - ram_accept_o = 1.
  - If ram_wr_i != 0: latch addr, len and strobes/data into the W holding register (wbuf); set beat count = 1; go to WRITE.
  - Else if ram_rd_i: latch addr and len; go to READ.
  - If both are asserted, the write wins and the read stays pending.
- WRITE:
  - axi_awvalid_o holds from WRITE entry until the awready handshake, then stays 0.
  - axi_wvalid_o = wbuf_valid; axi_wlast_o = 1 on the wbuf beat whose index equals len.
  - ram_accept_o = (ram_wr_i != 0) && (beat count <= len) && (!wbuf_valid || W handshake this cycle).
  - Each accept refills wbuf and increments the beat count.
  - Go to WRESP when the wlast beat has handshaken and AW is done, in either order or the same cycle.
- WRESP:
  - axi_bready_o = 1.
  - On bvalid: ram_ack_o pulses one cycle later, ram_error_o = (bresp != 0); go to IDLE.
- READ:
  - axi_arvalid_o = 1 until arready; axi_rready_o = 1 after AR is done.
  - Each R handshake registers rdata to ram_read_data_o and pulses ram_ack_o on the next cycle; ram_error_o = (rresp != 0).
  - The rlast handshake returns the FSM to IDLE.
- ram_accept_o = 0 in WRESP and READ. ram_rd_i is ignored outside IDLE.
- Beat count is 9 bits, so len = 255 gives 256 beats without wrap. AXI len is the latched ram_len_i, unmodified.
- axi_bid_i and axi_rid_i are ignored; there is only one outstanding transaction.

## Timing
- Reset values:
  - All axi_*valid_o, axi_bready_o, axi_rready_o, ram_ack_o and ram_error_o = 0.
  - ram_read_data_o and the address/len/data outputs = 0.
  - ram_accept_o = 1 (IDLE).
- Read request accepted at cycle N: arvalid asserts at N+1. An R beat at cycle M is acked at M+1.
- Write first beat accepted at N: awvalid and wvalid assert at N+1. A B handshake at M is acked at M+1.
- AXI valids never drop before their ready handshake.
- Reset asserted mid-burst: immediate return to IDLE with all outputs at reset values. The interconnect is reset in the same domain.
- Back-to-back: the request for the next burst is accepted in the first IDLE cycle after the final ack.

## Configuration
- PMEM_AXI_ERROR_RESP_EN defined: ram_error_o reflects bresp/rresp != 0 as described above.
- Not defined: ram_error_o is tied to 0 and responses are ignored apart from handshaking.

## Test plan
- Single read: ram_rd_i, addr 0x1000, len 0; slave returns 0xDEADBEEF with rlast -> one ram_ack_o with 0xDEADBEEF; arlen 0; back in IDLE.
- 4-beat write: len 3, addr 0x2000; wready toggles 1,0,1,1,1 -> exactly 4 W beats, wlast only on beat 4, awlen 3; one ram_ack_o after bvalid.
- AW handshake late: awready held low for 5 cycles after all W beats -> FSM waits in WRITE; WRESP entered only after the AW handshake; single ack.
- Simultaneous ram_wr_i and ram_rd_i in IDLE -> the write is issued first; the read is issued after the write ack; 2 acks total in that order.
- With PMEM_AXI_ERROR_RESP_EN defined, rresp = 2'b10 on beat 2 of a 3-beat read -> ram_error_o = 1 only with ack 2. Without the macro -> ram_error_o stays 0.
- Reset asserted during beat 2 of an 8-beat read -> all valids 0 immediately; after release a new 1-beat read completes normally.
